msf_pulse_classifier: RTL and testbench
=======================================

Name: msf_pulse_classifier

Overview:
Front-end stage of the MSF clock decoder. Takes the raw demodulated MSF receiver output, synchronises and glitch-filters it, and locks to the start-of-second carrier-off edge. For every second it classifies the pulse into bit A, bit B and the minute marker. It feeds one result per second to the downstream time-frame shift register and BCD decoder inside the top level.

Parameters:
TICK_CYCLES, 1000, clk_i cycles per 10 ms sample tick (>=2; benches use 4).

Ports:
clk_i        input   1  system clock
rst_ni       input   1  synchronous, active-low reset
data_i       input   1  raw receiver output, 1 = carrier off; asynchronous to clk_i
sec_valid_o  output  1  one-cycle pulse: new second classified
bit_a_o      output  1  bit A of last classified second; held between pulses
bit_b_o      output  1  bit B of last classified second; held between pulses
minute_o     output  1  last second was a minute marker (carrier off at 450 ms); held
err_o        output  1  one-cycle pulse: start pulse rejected as glitch
sync_o       output  1  level: locked to second edges

Behaviour:
- Reset: synchronous and active-low. When rst_ni=0 at a clk_i rising edge, all state and outputs go to 0 at that edge: prescaler, synchroniser, filter history, counters, FSM=WAIT_EDGE. Applies mid-operation; no partial result is emitted.
- Sync: data_i passes through a 2-flop synchroniser giving s.
- Prescaler: counts 0..TICK_CYCLES-1 and wraps. tick=1 for the one cycle at TICK_CYCLES-1.
- Filter: on tick, shift s into a 3-bit history. f is the registered majority of the history, updated on tick. A single-tick glitch never changes f.
- rise = f went 0->1 across two consecutive ticks. Evaluated on the tick following the f update; that tick is tick 0 of the second.
- Second counter sc: 7 bits, increments on tick, reset to 0 at rise. since_edge: 7 bits, saturates at 127, cleared at rise.
- FSM, all transitions on tick only:
  - WAIT_EDGE: on rise go to MEASURE with sc=0. While here, if since_edge reaches 110: sync_o<=0.
  - MEASURE:
    - sc==5: if f==0, err_o pulse, sync_o<=0, go to WAIT_EDGE.
    - sc==15: latch a=f.
    - sc==25: latch b=f.
    - sc==45: bit_a_o<=a, bit_b_o<=b, minute_o<=f, sec_valid_o pulse, sync_o<=1, go to HOLDOFF.
  - HOLDOFF: ignore f and rise. At sc==90 go to WAIT_EDGE.
- Minute marker (off 0–500 ms): reports minute_o=1, bit_a_o=1, bit_b_o=1. Downstream ignores the bits when minute_o=1.
- Output timing:
  - sec_valid_o and err_o are single-cycle, coincident with the decision tick.
  - bit_a_o, bit_b_o and minute_o update in the same cycle as sec_valid_o.
  - Latency from filtered rise to sec_valid_o is 45 ticks.
- Boundaries:
  - A rise during HOLDOFF is not latched; the next edge must occur in WAIT_EDGE.
  - Continuous carrier-off, or a missing second (e.g. leap/no-pulse): timeout after 110 ticks clears sync_o; no spurious sec_valid_o.
  - f stuck at 1: only one rise, then HOLDOFF, then WAIT_EDGE with no new rise; sync_o drops at since_edge 110.
  - err_o and sec_valid_o are never asserted in the same cycle.

Test Plan (TICK_CYCLES=4, times are from the filtered rise):
1. Off 0–100 ms, then carrier on -> sec_valid_o pulse at 450 ms; a=0, b=0, minute=0; sync_o=1.
2. Off 0–200 ms, then off 0–100 ms plus 200–300 ms -> first second a=1,b=0; second second a=0,b=1. Seconds are 1 s apart, each sec_valid_o exactly 45 ticks after its rise.
3. Off 0–500 ms -> minute_o=1, a=1, b=1. The following normal second clears minute_o.
4. 20 ms off pulse (2 ticks) -> err_o pulse at tick 5, no sec_valid_o, sync_o=0. A 1-tick pulse -> no err_o, no FSM exit from WAIT_EDGE.
5. After a locked second, hold data_i=0 for 2 s -> sync_o falls at since_edge=110, no sec_valid_o. Re-applying pulses relocks with sync_o=1 at the next valid second.
6. Assert rst_ni=0 for one cycle at 300 ms of a second -> all outputs 0 next cycle, no sec_valid_o for that second. Normal classification resumes on the next edge.

Source files
------------

// File: rtl/msf_pulse_classifier.sv
// MSF front end: synchronise and glitch-filter the demodulated carrier, lock to
// the start-of-second edge and classify each second into bit A, bit B and minute.
module msf_pulse_classifier #(
  parameter int TICK_CYCLES = 1000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic data_i,
  output logic sec_valid_o,
  output logic bit_a_o,
  output logic bit_b_o,
  output logic minute_o,
  output logic err_o,
  output logic sync_o
);

  localparam int PW = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_EDGE = 2'd0,
    MEASURE   = 2'd1,
    HOLDOFF   = 2'd2
  } state_t;

  logic          s_meta_q;
  logic          s_sync_q;
  logic [PW-1:0] pre_cnt_q;
  logic [2:0]    hist_q;
  logic          f_q;
  logic          f_prev_q;
  logic [6:0]    sc_q;
  logic [6:0]    since_q;
  state_t        state_q;
  logic          a_q;
  logic          b_q;

  logic          tick;
  logic [2:0]    hist_n;
  logic          maj;
  logic          rise;
  logic          edge_accept;
  logic [6:0]    sc_n;
  logic [6:0]    since_n;

  state_t        state_d;
  logic          a_d;
  logic          b_d;
  logic          valid_d;
  logic          err_d;
  logic          sync_d;
  logic          bit_a_d;
  logic          bit_b_d;
  logic          minute_d;

  assign tick   = (pre_cnt_q == PRE_MAX);
  assign hist_n = {hist_q[1:0], s_sync_q};
  assign maj    = (hist_n[0] & hist_n[1]) | (hist_n[0] & hist_n[2]) | (hist_n[1] & hist_n[2]);
  assign rise   = f_q & ~f_prev_q;

  // sc_n / since_n are the index of the current tick within the second, so the
  // decision points compare directly against 5, 15, 25, 45 and 90.
  assign edge_accept = tick && (state_q == WAIT_EDGE) && rise;
  assign sc_n        = edge_accept ? 7'd0 : sc_q + 7'd1;
  assign since_n     = edge_accept ? 7'd0 : ((since_q == 7'd127) ? 7'd127 : since_q + 7'd1);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    sync_d   = sync_o;
    bit_a_d  = bit_a_o;
    bit_b_d  = bit_b_o;
    minute_d = minute_o;
    if (tick) begin
      case (state_q)
        WAIT_EDGE: begin
          if (rise) begin
            state_d = MEASURE;
          end else if (since_n >= 7'd110) begin
            sync_d = 1'b0;
          end
        end
        MEASURE: begin
          if (sc_n == 7'd5 && !f_q) begin
            err_d   = 1'b1;
            sync_d  = 1'b0;
            state_d = WAIT_EDGE;
          end
          if (sc_n == 7'd15) a_d = f_q;
          if (sc_n == 7'd25) b_d = f_q;
          if (sc_n == 7'd45) begin
            bit_a_d  = a_q;
            bit_b_d  = b_q;
            minute_d = f_q;
            valid_d  = 1'b1;
            sync_d   = 1'b1;
            state_d  = HOLDOFF;
          end
        end
        HOLDOFF: begin
          if (sc_n == 7'd90) state_d = WAIT_EDGE;
        end
        default: state_d = WAIT_EDGE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s_meta_q    <= 1'b0;
      s_sync_q    <= 1'b0;
      pre_cnt_q   <= '0;
      hist_q      <= 3'b000;
      f_q         <= 1'b0;
      f_prev_q    <= 1'b0;
      sc_q        <= 7'd0;
      since_q     <= 7'd0;
      state_q     <= WAIT_EDGE;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      sec_valid_o <= 1'b0;
      err_o       <= 1'b0;
      sync_o      <= 1'b0;
      bit_a_o     <= 1'b0;
      bit_b_o     <= 1'b0;
      minute_o    <= 1'b0;
    end else begin
      s_meta_q  <= data_i;
      s_sync_q  <= s_meta_q;
      pre_cnt_q <= tick ? '0 : pre_cnt_q + PW'(1);
      if (tick) begin
        hist_q   <= hist_n;
        f_q      <= maj;
        f_prev_q <= f_q;
        sc_q     <= sc_n;
        since_q  <= since_n;
      end
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sec_valid_o <= valid_d;
      err_o       <= err_d;
      sync_o      <= sync_d;
      bit_a_o     <= bit_a_d;
      bit_b_o     <= bit_b_d;
      minute_o    <= minute_d;
    end
  end

endmodule

// File: tb/tb_msf_pulse_classifier.sv
// Bench for msf_pulse_classifier: one data sample per 10 ms tick, event-level
// reference model over the sampled waveform, scenario tasks compare event queues.
module tb_msf_pulse_classifier;

  localparam int TICK = 4;
  localparam int W    = 22;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic data_i = 1'b0;
  logic sec_valid_o, bit_a_o, bit_b_o, minute_o, err_o, sync_o;

  msf_pulse_classifier #(.TICK_CYCLES(TICK)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .data_i      (data_i),
    .sec_valid_o (sec_valid_o),
    .bit_a_o     (bit_a_o),
    .bit_b_o     (bit_b_o),
    .minute_o    (minute_o),
    .err_o       (err_o),
    .sync_o      (sync_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_fail = 0;

  // event word: {tick[15:0], valid, err, bit_a, bit_b, minute, sync}
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  logic [W-1:0] e, o;

  // reference model state; t counts ticks since the last reset
  int t;
  bit s_arr[0:8191];
  bit f_arr[0:8191];
  bit m_active, m_sync, m_sync_prev, m_a, m_b, m_m, m_valid, m_err;
  int m_r, m_wait_from, m_last_edge;

  bit obs_sync_prev;
  int last_valid_t, last_err_t, last_fall_t, n_valid_obs;

  function automatic bit sget(int i);
    return (i < 1) ? 1'b0 : s_arr[i];
  endfunction

  function automatic bit fget(int i);
    return (i < 1) ? 1'b0 : f_arr[i];
  endfunction

  task automatic model_tick(input bit v);
    bit in_wait, rise_t;
    t++;
    s_arr[t] = v;
    f_arr[t] = (int'(sget(t)) + int'(sget(t - 1)) + int'(sget(t - 2))) >= 2;
    m_valid = 0;
    m_err = 0;
    in_wait = !m_active && (t >= m_wait_from);
    rise_t = fget(t - 1) && !fget(t - 2);
    if (in_wait && rise_t) begin
      m_active = 1;
      m_r = t;
      m_last_edge = t;
    end else if (in_wait) begin
      if (t - m_last_edge >= 110) m_sync = 0;
    end else if (m_active) begin
      if (t - m_r == 5 && !fget(t - 1)) begin
        m_err = 1;
        m_sync = 0;
        m_active = 0;
        m_wait_from = t + 1;
      end else if (t - m_r == 45) begin
        m_valid = 1;
        m_a = fget(m_r + 14);
        m_b = fget(m_r + 24);
        m_m = fget(m_r + 44);
        m_sync = 1;
        m_active = 0;
        m_wait_from = m_r + 91;
      end
    end
    if (m_valid || m_err || (m_sync != m_sync_prev))
      exp_q.push_back({t[15:0], m_valid, m_err, m_a, m_b, m_m, m_sync});
    m_sync_prev = m_sync;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    t = 0;
    m_active = 0;
    m_wait_from = 1;
    m_last_edge = 0;
    m_sync = 0;
    m_sync_prev = 0;
    m_a = 0;
    m_b = 0;
    m_m = 0;
    obs_sync_prev = 0;
  endtask

  // drive one 10 ms sample and observe the outputs just after its tick edge
  task automatic step(input bit v);
    data_i = v;
    repeat (TICK) @(posedge clk);
    #1;
    model_tick(v);
    if (sec_valid_o === 1'b1 || err_o === 1'b1 || sync_o !== obs_sync_prev)
      obs_q.push_back({t[15:0], sec_valid_o, err_o, bit_a_o, bit_b_o, minute_o, sync_o});
    if (sec_valid_o === 1'b1) begin
      last_valid_t = t;
      n_valid_obs++;
    end
    if (err_o === 1'b1) last_err_t = t;
    if (obs_sync_prev && sync_o === 1'b0) last_fall_t = t;
    obs_sync_prev = (sync_o === 1'b1);
  endtask

  task automatic drive_second(input int off1_end, input int off2_start, input int off2_end, input int len);
    for (int i = 0; i < len; i++)
      step((i < off1_end) || (i >= off2_start && i < off2_end));
  endtask

  task automatic test_reset();
    data_i = 1'b0;
    do_reset();
    n_cmp++;
    if ({sec_valid_o, bit_a_o, bit_b_o, minute_o, err_o, sync_o} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 000000",
               {sec_valid_o, bit_a_o, bit_b_o, minute_o, err_o, sync_o});
    end
    for (int i = 0; i < 20; i++) step(1'b0);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL reset_event_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL reset_event: got %h required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_single_second();
    int k0;
    k0 = t + 1;
    drive_second(10, 0, 0, 100);
    n_cmp++;
    if (last_valid_t != k0 + 47) begin
      n_fail++; $display("FAIL single_latency: got tick %0d required %0d", last_valid_t, k0 + 47);
    end
    n_cmp++;
    if ({bit_a_o, bit_b_o, minute_o, sync_o} !== 4'b0001) begin
      n_fail++; $display("FAIL single_bits: got %b required 0001", {bit_a_o, bit_b_o, minute_o, sync_o});
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL single_event_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL single_event: got %h required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_bits();
    int k0;
    k0 = t + 1;
    drive_second(20, 0, 0, 100);
    n_cmp++;
    if (last_valid_t != k0 + 47 || {bit_a_o, bit_b_o, minute_o} !== 3'b100) begin
      n_fail++; $display("FAIL bits_a: got tick %0d abm %b required tick %0d abm 100",
                         last_valid_t, {bit_a_o, bit_b_o, minute_o}, k0 + 47);
    end
    drive_second(10, 20, 30, 100);
    n_cmp++;
    if (last_valid_t != k0 + 147 || {bit_a_o, bit_b_o, minute_o} !== 3'b010) begin
      n_fail++; $display("FAIL bits_b: got tick %0d abm %b required tick %0d abm 010",
                         last_valid_t, {bit_a_o, bit_b_o, minute_o}, k0 + 147);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL bits_event_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL bits_event: got %h required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_minute();
    drive_second(50, 0, 0, 100);
    n_cmp++;
    if ({bit_a_o, bit_b_o, minute_o} !== 3'b111) begin
      n_fail++; $display("FAIL minute_marker: got abm %b required 111", {bit_a_o, bit_b_o, minute_o});
    end
    drive_second(10, 0, 0, 100);
    n_cmp++;
    if ({bit_a_o, bit_b_o, minute_o} !== 3'b000) begin
      n_fail++; $display("FAIL minute_clear: got abm %b required 000", {bit_a_o, bit_b_o, minute_o});
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL minute_event_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL minute_event: got %h required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_glitch();
    int k0, nv;
    k0 = t + 1;
    nv = n_valid_obs;
    drive_second(2, 0, 0, 100);
    n_cmp++;
    if (last_err_t != k0 + 7 || sync_o !== 1'b0 || n_valid_obs != nv) begin
      n_fail++; $display("FAIL glitch_err: got err tick %0d sync %b valids %0d required tick %0d sync 0 valids %0d",
                         last_err_t, sync_o, n_valid_obs - nv, k0 + 7, 0);
    end
    drive_second(1, 0, 0, 100);
    n_cmp++;
    if (last_err_t != k0 + 7 || n_valid_obs != nv) begin
      n_fail++; $display("FAIL glitch_single_tick: got err tick %0d valids %0d required tick %0d valids 0",
                         last_err_t, n_valid_obs - nv, k0 + 7);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL glitch_event_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL glitch_event: got %h required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_timeout();
    int k0, nv;
    k0 = t + 1;
    drive_second(10, 0, 0, 100);
    nv = n_valid_obs;
    for (int i = 0; i < 200; i++) step(1'b0);
    n_cmp++;
    if (last_fall_t != k0 + 112 || n_valid_obs != nv) begin
      n_fail++; $display("FAIL timeout_sync: got fall tick %0d valids %0d required tick %0d valids 0",
                         last_fall_t, n_valid_obs - nv, k0 + 112);
    end
    drive_second(10, 0, 0, 100);
    drive_second(20, 0, 0, 100);
    n_cmp++;
    if (sync_o !== 1'b1 || bit_a_o !== 1'b1 || n_valid_obs != nv + 2) begin
      n_fail++; $display("FAIL timeout_relock: got sync %b a %b valids %0d required sync 1 a 1 valids 2",
                         sync_o, bit_a_o, n_valid_obs - nv);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL timeout_event_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL timeout_event: got %h required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    int nv;
    drive_second(20, 0, 0, 100);
    drive_second(10, 0, 0, 30);
    n_cmp++;
    if (sync_o !== 1'b1 || bit_a_o !== 1'b1) begin
      n_fail++; $display("FAIL midreset_pre: got sync %b a %b required sync 1 a 1", sync_o, bit_a_o);
    end
    do_reset();
    n_cmp++;
    if ({sec_valid_o, bit_a_o, bit_b_o, minute_o, err_o, sync_o} !== 6'b0) begin
      n_fail++; $display("FAIL midreset_outputs: got %b required 000000",
                         {sec_valid_o, bit_a_o, bit_b_o, minute_o, err_o, sync_o});
    end
    nv = n_valid_obs;
    for (int i = 0; i < 70; i++) step(1'b0);
    n_cmp++;
    if (n_valid_obs != nv) begin
      n_fail++; $display("FAIL midreset_no_valid: got %0d valids required 0", n_valid_obs - nv);
    end
    drive_second(10, 20, 30, 100);
    n_cmp++;
    if ({bit_a_o, bit_b_o, minute_o, sync_o} !== 4'b0101 || n_valid_obs != nv + 1) begin
      n_fail++; $display("FAIL midreset_resume: got abms %b valids %0d required 0101 valids 1",
                         {bit_a_o, bit_b_o, minute_o, sync_o}, n_valid_obs - nv);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL midreset_event_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL midreset_event: got %h required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random();
    int len, o1, o2s, o2e;
    bit v;
    for (int sec = 0; sec < 16; sec++) begin
      len = $urandom_range(80, 115);
      o1  = $urandom_range(0, 55);
      o2s = $urandom_range(10, 30);
      o2e = o2s + $urandom_range(0, 12);
      for (int i = 0; i < len; i++) begin
        v = (i < o1) || (i >= o2s && i < o2e);
        if ($urandom_range(0, 29) == 0) v = !v;
        step(v);
      end
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL random_event_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL random_event: got %h required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    last_valid_t = -1;
    last_err_t = -1;
    last_fall_t = -1;
    n_valid_obs = 0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_second();
    test_bits();
    test_minute();
    test_glitch();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
